// File: rtl/if_fetch_queue_pkg.sv
// Shared widths and constants for the instruction fetch queue.
package if_fetch_queue_pkg;

  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned InstBus     = 32;
  localparam int unsigned FetchQDepth = 4;

  localparam logic [InstBus-1:0] ZeroWord = '0;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with synchronous flush, occupancy count and
// combinational head read.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != CntW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Pointers rely on DEPTH being a power of two to wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the consumer gates the head with count.
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch address generator for a 1-cycle synchronous instruction memory,
// buffering returned {pc, inst} pairs in a queue toward ID.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int unsigned       ADDR_W   = InstAddrBus,
  parameter int unsigned       INST_W   = InstBus,
  parameter int unsigned       DEPTH    = FetchQDepth,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   ce,
  output logic [ADDR_W-1:0]      pc,
  input  logic [INST_W-1:0]      rom_inst,
  input  logic                   branch_flag_i,
  input  logic [ADDR_W-1:0]      branch_target_i,
  input  logic                   stall_i,
  output logic                   id_valid,
  output logic [ADDR_W-1:0]      id_pc,
  output logic [INST_W-1:0]      id_inst,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned CntW   = $clog2(DEPTH) + 1;
  localparam int unsigned ResW   = CntW + 1;
  localparam int unsigned EntryW = ADDR_W + INST_W;

  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic [ResW-1:0]   reserved;
  logic              issue;
  logic              push;
  logic              pop;
  logic [EntryW-1:0] head;

  // Every outstanding fetch already owns a queue slot, so pushes never overflow.
  assign reserved = ResW'(count) + ResW'(inflight);
  assign issue    = ce && !branch_flag_i && (reserved < ResW'(DEPTH));
  assign push     = inflight && !branch_flag_i;
  assign pop      = id_valid && !stall_i && !branch_flag_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      ce          <= 1'b0;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      ce <= 1'b1;
      if (branch_flag_i) begin
        pc       <= branch_target_i;
        inflight <= 1'b0;
      end else begin
        inflight <= issue;
        if (issue) begin
          pc          <= pc + ADDR_W'(PC_STEP);
          inflight_pc <= pc;
        end
      end
    end
  end

  fetch_fifo #(
    .WIDTH (EntryW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (branch_flag_i),
    .push  (push),
    .pop   (pop),
    .din   ({inflight_pc, rom_inst}),
    .head  (head),
    .count (count)
  );

  // An empty queue presents a NOP bubble.
  assign id_valid = (count != '0);
  assign id_pc    = id_valid ? head[EntryW-1:INST_W] : ADDR_W'(ZeroWord);
  assign id_inst  = id_valid ? head[INST_W-1:0]      : INST_W'(ZeroWord);

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a scoreboard of expected fetch pcs.
module tb_if_fetch_queue;

  logic        clk;
  logic        rst;
  logic        ce;
  logic [31:0] pc;
  logic [31:0] rom_inst;
  logic        branch;
  logic [31:0] target;
  logic        stall;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [2:0]  count;

  logic        rst2;
  logic        ce2;
  logic [31:0] pc2;
  logic [31:0] rom2;
  logic        branch2;
  logic [31:0] target2;
  logic        stall2;
  logic        id_valid2;
  logic [31:0] id_pc2;
  logic [31:0] id_inst2;
  logic [2:0]  count2;

  logic [31:0] sb[$];
  int n_asserts = 0;
  int n_fails   = 0;

  if_fetch_queue dut (
    .clk(clk), .rst(rst), .ce(ce), .pc(pc), .rom_inst(rom_inst),
    .branch_flag_i(branch), .branch_target_i(target), .stall_i(stall),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .count(count)
  );

  if_fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst2), .ce(ce2), .pc(pc2), .rom_inst(rom2),
    .branch_flag_i(branch2), .branch_target_i(target2), .stall_i(stall2),
    .id_valid(id_valid2), .id_pc(id_pc2), .id_inst(id_inst2), .count(count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory models: one-cycle latency, word = address | 2.
  always @(posedge clk) if (ce)  rom_inst <= pc  | 32'h2;
  always @(posedge clk) if (ce2) rom2     <= pc2 | 32'h2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic v, input logic [31:0] p,
                           input logic [31:0] i);
    logic [31:0] e;
    if (sb.size() == 0) begin
      n_asserts++;
      n_fails++;
      $error("FAIL %s scoreboard empty, observed pc=%0h", tag, p);
      return;
    end
    e = sb.pop_front();
    check({tag, "_valid"}, 64'(v), 64'd1);
    check({tag, "_pc"},    64'(p), 64'(e));
    check({tag, "_inst"},  64'(i), 64'(e | 32'h2));
  endtask

  task automatic wait_full(input string tag);
    int c = 0;
    while (count !== 3'd4 && c < 20) begin
      @(negedge clk);
      c++;
    end
    check(tag, 64'(count), 64'd4);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch = 1'b0; target = '0;
    rst2 = 1'b1; stall2 = 1'b0; branch2 = 1'b0; target2 = '0;
    repeat (2) @(negedge clk);

    check("rst_ce",       64'(ce),       64'd0);
    check("rst_pc",       64'(pc),       64'd0);
    check("rst_count",    64'(count),    64'd0);
    check("rst_valid",    64'(id_valid), 64'd0);
    check("rst_id_pc",    64'(id_pc),    64'd0);
    check("rst_id_inst",  64'(id_inst),  64'd0);
    check("rst_wrap_pc",  64'(pc2),      64'hFFFF_FFF8);
    check("rst_wrap_ce",  64'(ce2),      64'd0);

    // Sequential fetch, no stall.
    for (int k = 0; k < 6; k++) sb.push_back(32'(k * 4));
    rst = 1'b0;
    @(negedge clk);
    check("t1_ce",      64'(ce),       64'd1);
    check("t1_pc_hold", 64'(pc),       64'd0);
    @(negedge clk);
    check("t1_bubble",  64'(id_valid), 64'd0);
    check("t1_pc_step", 64'(pc),       64'd4);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      pop_check("t1", id_valid, id_pc, id_inst);
    end

    // Stall from the start: queue fills, pc freezes, then drains in order.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; stall = 1'b1;
    repeat (6) @(negedge clk);
    check("t2_count_full", 64'(count), 64'd4);
    check("t2_pc_frozen",  64'(pc),    64'h10);
    repeat (3) @(negedge clk);
    check("t2_pc_still",   64'(pc),    64'h10);
    check("t2_count_still",64'(count), 64'd4);
    for (int k = 0; k < 6; k++) sb.push_back(32'(k * 4));
    stall = 1'b0;
    for (int k = 0; k < 6; k++) begin
      pop_check("t2", id_valid, id_pc, id_inst);
      @(negedge clk);
    end

    // Branch with three queued and one in flight.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; stall = 1'b1;
    repeat (5) @(negedge clk);
    check("t3_count3", 64'(count), 64'd3);
    branch = 1'b1; target = 32'h100;
    @(negedge clk);
    check("t3_flush_valid", 64'(id_valid), 64'd0);
    check("t3_flush_count", 64'(count),    64'd0);
    check("t3_pc_target",   64'(pc),       64'h100);
    branch = 1'b0; stall = 1'b0;
    sb.push_back(32'h100); sb.push_back(32'h104); sb.push_back(32'h108);
    @(negedge clk);
    check("t3_gap", 64'(id_valid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      pop_check("t3", id_valid, id_pc, id_inst);
    end

    // Branch while stalled with a full queue.
    stall = 1'b1;
    wait_full("t4_fill");
    branch = 1'b1; target = 32'h200;
    @(negedge clk);
    check("t4_flush_count", 64'(count),    64'd0);
    check("t4_flush_valid", 64'(id_valid), 64'd0);
    branch = 1'b0;
    sb.push_back(32'h200);
    @(negedge clk);
    check("t4_gap", 64'(id_valid), 64'd0);
    @(negedge clk);
    pop_check("t4", id_valid, id_pc, id_inst);

    // Reset mid-stream overrides branch and stall.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; stall = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_count2", 64'(count), 64'd2);
    rst = 1'b1; branch = 1'b1; target = 32'h300;
    @(negedge clk);
    check("t5_count", 64'(count),    64'd0);
    check("t5_valid", 64'(id_valid), 64'd0);
    check("t5_pc",    64'(pc),       64'd0);
    check("t5_ce",    64'(ce),       64'd0);
    rst = 1'b0; branch = 1'b0; stall = 1'b0;

    // Address wrap from a high reset vector.
    sb.push_back(32'hFFFF_FFF8); sb.push_back(32'hFFFF_FFFC);
    sb.push_back(32'h0);         sb.push_back(32'h4);
    rst2 = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pop_check("t6", id_valid2, id_pc2, id_inst2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
